// File: rtl/reg_file_pkg.sv
// Shared types and defaults for the register file / scoreboard slice.
package reg_file_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam logic [ADDR_W_DEF-1:0] ZERO_REG = '0;

    typedef logic [ADDR_W_DEF-1:0] reg_addr_t;
    typedef logic [DATA_W_DEF-1:0] reg_data_t;

endpackage

// File: rtl/reg_file_sb_wen_decode.sv
// Gated one-hot address decoder; bit 0 is always masked off because register 0 is hardwired.
module wen_decode import reg_file_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 en,
    input  logic [ADDR_W-1:0]    addr,
    output logic [2**ADDR_W-1:0] onehot
);

    localparam int NREGS = 2**ADDR_W;

    for (genvar gi = 0; gi < NREGS; gi++) begin : gDecode
        if (gi == 0) begin : gZero
            assign onehot[gi] = 1'b0;
        end else begin : gSel
            assign onehot[gi] = en & (addr == ADDR_W'(gi));
        end
    end

endmodule

// File: rtl/reg_file_sb.sv
// Register file with one write port, two combinational read ports and a busy scoreboard.
// Optional same-cycle write-to-read bypass is enabled by defining REG_FILE_BYPASS_EN.
module reg_file_sb import reg_file_pkg::*; #(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 RegWrite,
    input  logic [ADDR_W-1:0]    WriteRegister,
    input  logic [DATA_W-1:0]    WriteData,
    input  logic [ADDR_W-1:0]    ReadRegister1,
    input  logic [ADDR_W-1:0]    ReadRegister2,
    output logic [DATA_W-1:0]    ReadData1,
    output logic [DATA_W-1:0]    ReadData2,
    input  logic                 IssueEn,
    input  logic [ADDR_W-1:0]    IssueReg,
    output logic                 Busy1,
    output logic                 Busy2,
    output logic [2**ADDR_W-1:0] WriteEn,
    output logic [2**ADDR_W-1:0] BusyVec
);

    localparam int NREGS = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);

    logic [DATA_W-1:0] regsReg [NREGS];
    logic [NREGS-1:0]  busyReg;
    logic [NREGS-1:0]  busyNext;
    logic [NREGS-1:0]  setVec;

    wen_decode #(.ADDR_W(ADDR_W)) uWriteDecode (
        .en     (RegWrite),
        .addr   (WriteRegister),
        .onehot (WriteEn)
    );

    wen_decode #(.ADDR_W(ADDR_W)) uIssueDecode (
        .en     (IssueEn),
        .addr   (IssueReg),
        .onehot (setVec)
    );

    // A new reservation beats a retiring write to the same register.
    for (genvar gi = 0; gi < NREGS; gi++) begin : gBusy
        if (gi == 0) begin : gZero
            assign busyNext[gi] = 1'b0;
        end else begin : gReg
            assign busyNext[gi] = setVec[gi] | (busyReg[gi] & ~WriteEn[gi]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busyReg <= '0;
            for (int i = 0; i < NREGS; i++) begin
                regsReg[i] <= '0;
            end
        end else begin
            busyReg <= busyNext;
            for (int i = 1; i < NREGS; i++) begin
                if (WriteEn[i]) begin
                    regsReg[i] <= WriteData;
                end
            end
        end
    end

    assign BusyVec = busyReg;

    always_comb begin
        ReadData1 = (ReadRegister1 == ZERO_ADDR) ? '0 : regsReg[ReadRegister1];
        ReadData2 = (ReadRegister2 == ZERO_ADDR) ? '0 : regsReg[ReadRegister2];
        Busy1     = busyReg[ReadRegister1];
        Busy2     = busyReg[ReadRegister2];
`ifdef REG_FILE_BYPASS_EN
        // The retiring write satisfies the reader now, unless the same register is being re-reserved.
        if (RegWrite && (WriteRegister != ZERO_ADDR) && (WriteRegister == ReadRegister1)) begin
            ReadData1 = WriteData;
            if (!(IssueEn && (IssueReg == ReadRegister1))) begin
                Busy1 = 1'b0;
            end
        end
        if (RegWrite && (WriteRegister != ZERO_ADDR) && (WriteRegister == ReadRegister2)) begin
            ReadData2 = WriteData;
            if (!(IssueEn && (IssueReg == ReadRegister2))) begin
                Busy2 = 1'b0;
            end
        end
`endif
    end

endmodule
